// File: rtl/mem_pkg.sv
// Shared encodings for the memory access controller: access sizes, FSM states, RAM geometry.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_pkg;

    localparam int RAM_ADDR_W = 9;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WR     = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // True for an access the RAM path cannot serve: illegal size or misaligned offset.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Big-endian lane logic: load extract + sign/zero extend, and store lane merge into a word.
// Latency: purely combinational.
// Backpressure: none.
//   word     : 32-bit word read from RAM
//   off      : byte offset within the word (addr[1:0])
//   size     : access size encoding
//   uns      : 1 = zero-extend loads, 0 = sign-extend
//   wdata    : right-justified store data (only a byte or half is ever merged)
//   load_val : aligned, extended load result
//   merged   : word with only the addressed lane replaced
module mem_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [15:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Offset 0 is the most significant lane.
    always_comb begin
        byte_lane = word[7:0];
        case (off)
            2'd0: byte_lane = word[31:24];
            2'd1: byte_lane = word[23:16];
            2'd2: byte_lane = word[15:8];
            2'd3: byte_lane = word[7:0];
            default: byte_lane = word[7:0];
        endcase
        half_lane = off[1] ? word[15:0] : word[31:16];
    end

    always_comb begin
        load_val = word;
        case (size)
            SZ_BYTE: load_val = {{24{~uns & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_val = {{16{~uns & half_lane[15]}}, half_lane};
            default: load_val = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0: merged[31:24] = wdata[7:0];
                    2'd1: merged[23:16] = wdata[7:0];
                    2'd2: merged[15:8]  = wdata[7:0];
                    2'd3: merged[7:0]   = wdata[7:0];
                    default: merged = word;
                endcase
            end
            SZ_HALF: begin
                if (off[1]) merged[15:0]  = wdata;
                else        merged[31:16] = wdata;
            end
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Load/store controller for a word-only RAM: one request at a time, RMW for byte/half stores.
// Latency: load/word store done at T1, byte/half store at T2, rejected access at T0 (T0 = accept edge).
// Backpressure: busy high outside IDLE; req is ignored until the FSM returns to IDLE (no queueing).
//   clk, rst           : clock, async active-high reset
//   req/wr/size/uns    : request strobe and attributes, sampled in IDLE only
//   addr/wdata         : byte address and right-justified store data
//   busy/done/err      : status; err qualifies done
//   rdata              : last successful load result
//   ram_*              : RAM strobes, decoded from registered state
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              ram_nce,
    output logic              ram_re,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    state_t state_q, state_d;

    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        uns_q;
    logic [15:0] wdata_q;
    logic        err_q;

    logic        accept;
    logic        bad;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Upper address bits fall outside the RAM and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign accept = (state_q == ST_IDLE) && req;
    assign bad    = is_bad_access(size, addr[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (bad)                 state_d = ST_DONE;
                    else if (!wr)            state_d = ST_RD;
                    else if (size == SZ_WORD) state_d = ST_WR;
                    else                     state_d = ST_RMW_RD;
                end
            end
            ST_RD:     state_d = ST_DONE;
            ST_RMW_RD: state_d = ST_WR;
            ST_WR:     state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request latch and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_q   <= SZ_BYTE;
            off_q    <= 2'd0;
            uns_q    <= 1'b0;
            wdata_q  <= 16'd0;
            err_q    <= 1'b0;
            ram_addr <= '0;
            ram_din  <= 32'd0;
            rdata    <= 32'd0;
        end else begin
            if (accept) begin
                size_q   <= size;
                off_q    <= addr[1:0];
                uns_q    <= uns;
                wdata_q  <= wdata[15:0];
                err_q    <= bad;
                ram_addr <= addr[ADDR_W+1:2];
                // Word stores need no read; the data goes straight to the RAM.
                if (wr && (size == SZ_WORD) && !bad)
                    ram_din <= wdata;
            end
            if (state_q == ST_RMW_RD)
                ram_din <= merged;
            if (state_q == ST_RD)
                rdata <= load_val;
            if (state_q == ST_DONE)
                err_q <= 1'b0;
        end
    end

    mem_align u_align (
        .word     (ram_dout),
        .off      (off_q),
        .size     (size_q),
        .uns      (uns_q),
        .wdata    (wdata_q),
        .load_val (load_val),
        .merged   (merged)
    );

    // Strobes are pure decodes of the state register, so reset kills them immediately.
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign err     = (state_q == ST_DONE) && err_q;
    assign ram_re  = (state_q == ST_RD) || (state_q == ST_RMW_RD);
    assign ram_we  = (state_q == ST_WR);
    assign ram_nce = !(ram_re || ram_we);

endmodule
